mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4:1 multiplexer among four requesters.
//   Drives the mux select lines s1,s0 from the current grant, so the mux output f
//   carries the granted requester's signal. Registered, single-clock control block.
//   Sits in front of mux_4x1 (x=req0, y=req1, z=req2, v=req3 data).
// PARAMETERS
//   MAX_HOLD  4  max consecutive grant cycles while another requester waits; 0 = unlimited
// PORTS
//   clk    in   1  clock, all state updates on rising edge
//   rst    in   1  synchronous, active-high reset
//   req    in   4  request per source; req[i] held high while source i wants the mux
//   gnt    out  4  one-hot grant; all zero when idle
//   s1     out  1  mux select MSB, = granted index bit 1
//   s0     out  1  mux select LSB, = granted index bit 0
//   busy   out  1  high while any grant is active
// BEHAVIOUR
//   - Reset: gnt=0000, s1s0=00, busy=0, pointer ptr=0, hold_cnt=0, state IDLE.
//   - State: IDLE (no grant), GRANT (gnt one-hot, idx = granted index).
//   - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first requester found wins.
//   - IDLE: if req!=0 at an edge, enter GRANT at that edge with the winner.
//     One-cycle latency: req rises in cycle n, gnt is high in cycle n+1.
//     busy=1, hold_cnt=1.
//   - GRANT, per edge:
//     a) req[idx]=0 -> release.
//     b) MAX_HOLD!=0, hold_cnt==MAX_HOLD, and another req bit set -> release (preempt).
//     c) otherwise keep the grant; hold_cnt increments and saturates at MAX_HOLD.
//   - Release: ptr <= idx+1 (mod 4, 3 wraps to 0). Search the other requesters at the same edge:
//     - If found: grant it directly, with no idle cycle and hold_cnt=1.
//     - If none found: go to IDLE, gnt=0000, busy=0.
//   - Search at release excludes idx even if req[idx] is still high. The source re-wins later by rotation.
//   - Without a competitor, a grant is never preempted, even after MAX_HOLD cycles.
//   - s1s0 updates only at the same edge as gnt. In IDLE, s1s0 keeps the last granted index.
//     The mux select never toggles without a grant change.
//   - Requests that rise in the same cycle as a release are included in that edge's search.
//   - gnt is always one-hot or zero. s1s0 always equals the encoding of gnt while busy=1.
//   - Reset mid-grant: at the next edge all outputs and state return to reset values.
//     Any pending req is granted no earlier than one cycle after rst falls.
// TESTING
//   1. rst, then req=0001 held 3 cycles then 0000 -> gnt=0001, s1s0=00, busy=1 from the
//      cycle after req rises. gnt=0000, busy=0 one cycle after req drops.
//   2. MAX_HOLD=4, req=1111 held -> gnt 0001 x4 cycles, 0010 x4, 0100 x4, 1000 x4,
//      then 0001 again. s1s0 steps 00,01,10,11,00 with no gap cycles.
//   3. req=0100 alone held 10 cycles -> gnt=0100, s1s0=10 for all 10 cycles (no preempt).
//   4. Grant to 3 (s1s0=11), then req=1001 with req[3] dropped -> next gnt=0001, s1s0=00
//      (pointer wrap 3->0).
//   5. req=1111, rst pulsed 1 cycle during grant to 1 -> next edge gnt=0000, s1s0=00,
//      busy=0. One cycle after rst falls, gnt=0001.
//   6. Integrated with mux_4x1, x,y,z,v=1,0,1,0, req=1111, MAX_HOLD=1 -> f follows
//      1,0,1,0 per grant cycle after the mux gate delay. gnt is never multi-hot.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
// Grant, mux select and busy are all registered; a holder can be preempted after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no grant active; s1/s0 keep the last granted index
// GRANT | gnt is one-hot at idx, hold_cnt counts consecutive grant cycles
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy
);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [3:0]    others;
    logic          do_release;

    // First set bit of vec, scanning upward from start with wrap at 3 -> 0.
    function automatic logic [1:0] pick(input logic [3:0] vec, input logic [1:0] start);
        logic [1:0] cand;
        logic       found;
        logic [1:0] win;
        win   = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = start + 2'(k);
            if (!found && vec[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        ptr_nxt    = ptr;
        hold_nxt   = hold_cnt;
        others     = req & ~(4'b0001 << idx);
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick(req, ptr);
                    hold_nxt  = HOLD_ONE;
                end
            end
            GRANT: begin
                do_release = !req[idx] ||
                             ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && (others != 4'b0000));
                if (do_release) begin
                    ptr_nxt = idx + 2'd1;
                    // The current holder is masked out so it only re-wins by rotation.
                    if (others != 4'b0000) begin
                        idx_nxt  = pick(others, idx + 2'd1);
                        hold_nxt = HOLD_ONE;
                    end else begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt < HOLD_MAX)) begin
                    hold_nxt = hold_cnt + HOLD_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == GRANT);
    assign gnt  = busy ? (4'b0001 << idx) : 4'b0000;
    assign s1   = idx[1];
    assign s0   = idx[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed sequences plus random traffic, two instances
// (MAX_HOLD=4 and MAX_HOLD=1 driving a modelled 4:1 mux) checked against a rule-level model.
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt_a, gnt_b;
    logic       s1_a, s0_a, busy_a;
    logic       s1_b, s0_b, busy_b;
    logic [3:0] mux_data;
    logic       f_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, one slot per instance: 0 -> MAX_HOLD=4, 1 -> MAX_HOLD=1.
    int m_busy[2];
    int m_idx[2];
    int m_ptr[2];
    int m_hold[2];
    int m_mh[2];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .s1(s1_a), .s0(s0_a), .busy(busy_a)
    );
    mux4_rr_arbiter #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .s1(s1_b), .s0(s0_b), .busy(busy_b)
    );

    // mux_4x1 stand-in: x,y,z,v = mux_data[0..3], with a 2 ns gate delay.
    assign #2 f_b = mux_data[{s1_b, s0_b}];

    function automatic void model_step(int k, bit r, logic [3:0] rq);
        int others_cnt;
        int cand;
        bit found;
        if (r) begin
            m_busy[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_hold[k] = 0;
            return;
        end
        if (m_busy[k] == 0) begin
            found = 0;
            for (int o = 0; o < 4; o++) begin
                cand = (m_ptr[k] + o) % 4;
                if (!found && rq[cand]) begin
                    found = 1; m_idx[k] = cand;
                end
            end
            if (found) begin
                m_busy[k] = 1; m_hold[k] = 1;
            end
        end else begin
            others_cnt = 0;
            for (int o = 0; o < 4; o++)
                if (o != m_idx[k] && rq[o]) others_cnt++;
            if (!rq[m_idx[k]] || (m_mh[k] != 0 && m_hold[k] == m_mh[k] && others_cnt > 0)) begin
                m_ptr[k] = (m_idx[k] + 1) % 4;
                if (others_cnt > 0) begin
                    found = 0;
                    for (int o = 0; o < 3; o++) begin
                        cand = (m_ptr[k] + o) % 4;
                        if (!found && rq[cand]) begin
                            found = 1; m_idx[k] = cand;
                        end
                    end
                    m_hold[k] = 1;
                end else begin
                    m_busy[k] = 0; m_hold[k] = 0;
                end
            end else if (m_mh[k] != 0 && m_hold[k] < m_mh[k]) begin
                m_hold[k]++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] eg;
        for (int k = 0; k < 2; k++) begin
            eg = (m_busy[k] != 0) ? 4'(1 << m_idx[k]) : 4'b0000;
            if (k == 0) begin
                check({tag, ".a.gnt"},  gnt_a, eg);
                check({tag, ".a.sel"},  {2'b00, s1_a, s0_a}, 4'(m_idx[k]));
                check({tag, ".a.busy"}, {3'b000, busy_a}, 4'(m_busy[k]));
                check({tag, ".a.onehot0"}, {3'b000, $onehot0(gnt_a)}, 4'b0001);
            end else begin
                check({tag, ".b.gnt"},  gnt_b, eg);
                check({tag, ".b.sel"},  {2'b00, s1_b, s0_b}, 4'(m_idx[k]));
                check({tag, ".b.busy"}, {3'b000, busy_b}, 4'(m_busy[k]));
                check({tag, ".b.f"},    {3'b000, f_b}, {3'b000, mux_data[m_idx[k]]});
            end
        end
    endtask

    task automatic do_cycle(input string tag, input bit r, input logic [3:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        @(posedge clk);
        model_step(0, r, rq);
        model_step(1, r, rq);
        #3;
        check_outputs(tag);
    endtask

    initial begin
        m_mh[0] = 4; m_mh[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_hold[k] = 0;
        end
        mux_data = 4'b0101;
        rst = 1'b1;
        req = 4'b0000;

        do_cycle("reset", 1'b1, 4'b0000);
        do_cycle("reset", 1'b1, 4'b0000);

        // Single requester, then drop.
        for (int i = 0; i < 3; i++) do_cycle("single0", 1'b0, 4'b0001);
        do_cycle("drop0", 1'b0, 4'b0000);
        do_cycle("idle", 1'b0, 4'b0000);

        // Full contention: rotation every MAX_HOLD cycles, no gaps.
        do_cycle("rst2", 1'b1, 4'b0000);
        for (int i = 0; i < 18; i++) do_cycle("all_req", 1'b0, 4'b1111);

        // Lone requester is never preempted.
        do_cycle("rst3", 1'b1, 4'b0000);
        for (int i = 0; i < 11; i++) do_cycle("lone2", 1'b0, 4'b0100);

        // Pointer wrap 3 -> 0.
        do_cycle("gap", 1'b0, 4'b0000);
        for (int i = 0; i < 2; i++) do_cycle("hold3", 1'b0, 4'b1000);
        do_cycle("wrap", 1'b0, 4'b0001);
        for (int i = 0; i < 6; i++) do_cycle("pair", 1'b0, 4'b1001);

        // Reset pulse during grant to source 1.
        do_cycle("rst5", 1'b1, 4'b1111);
        for (int i = 0; i < 5; i++) do_cycle("pre_rst", 1'b0, 4'b1111);
        do_cycle("mid_rst", 1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) do_cycle("post_rst", 1'b0, 4'b1111);

        // Random traffic with sticky-ish requests and occasional resets.
        req = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rq;
            bit         r;
            rq = req;
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 2) == 0) rq[$urandom_range(0, 3)] = ~rq[$urandom_range(0, 3)];
            r = ($urandom_range(0, 49) == 0);
            do_cycle("random", r, rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
